// File: rtl/dm_arb_pkg.sv
// Shared encodings for the DM arbiter: LAST owner states and read-return owner tags.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dm_arb_pkg;

  // LAST: owner of the previous cycle's DM access
  localparam logic [1:0] L_NONE = 2'd0;
  localparam logic [1:0] L_CORE = 2'd1;
  localparam logic [1:0] L_DMA  = 2'd2;

  // Owner tag {core, dma} for the read-data return cycle
  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_CORE = 2'b10;
  localparam logic [1:0] TAG_DMA  = 2'b01;

  // Width of the DMA starvation counter
  localparam int STARVE_W = 4;

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// DMA starvation counter: counts cycles DMA waits while requesting, saturates at the limit.
// Latency: starve flag is registered; it forces DMA priority on the cycle after reaching the limit.
// Backpressure: none; counter clears whenever DMA is granted.
module dm_arb_starve_ctr
  import dm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic starve
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_LIMIT[STARVE_W-1:0];

  logic [STARVE_W-1:0] cnt;

  // Count waiting cycles, hold at the limit, clear on a DMA grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (dma_gnt) begin
      cnt <= '0;
    end else if (dma_req && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starve = (cnt == LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port (core/DMA) arbiter onto a single DM port; core-first, optional DMA aging via DM_ARB_AGING_EN.
// Latency: grant and address phase same cycle; write data and read return one cycle later.
// Backpressure: a losing requester holds req until gnt; one grant per cycle, back-to-back allowed.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DMA_SIZE     = 17,
  parameter int DMD_SIZE     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  input  logic                core_wrb,
  input  logic [DMA_SIZE-1:0] core_add,
  input  logic [DMD_SIZE-1:0] core_wdt,
  output logic                core_gnt,
  output logic                core_rvld,
  output logic [DMD_SIZE-1:0] core_rdt,
  input  logic                dma_req,
  input  logic                dma_wrb,
  input  logic [DMA_SIZE-1:0] dma_add,
  input  logic [DMD_SIZE-1:0] dma_wdt,
  output logic                dma_gnt,
  output logic                dma_rvld,
  output logic [DMD_SIZE-1:0] dma_rdt,
  output logic                arb_dm_cslt,
  output logic                arb_dm_wrb,
  output logic [DMA_SIZE-1:0] arb_dm_add,
  output logic [DMD_SIZE-1:0] arb_dm_wdt,
  input  logic [DMD_SIZE-1:0] dm_arb_dt
);

  logic                dma_force;
  logic                any_gnt;
  logic                sel_wrb;
  logic [DMA_SIZE-1:0] sel_add;
  logic [DMD_SIZE-1:0] sel_wdt;
  logic [1:0]          last;
  logic                last_rd;
  logic [1:0]          tag;
  logic                wrb_q;
  logic [DMA_SIZE-1:0] add_q;
  logic [DMD_SIZE-1:0] wdt_q;
  logic [DMD_SIZE-1:0] core_rdt_q;
  logic [DMD_SIZE-1:0] dma_rdt_q;

`ifdef DM_ARB_AGING_EN
  logic starve;

  dm_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .dma_req (dma_req),
    .dma_gnt (dma_gnt),
    .starve  (starve)
  );

  // A starved DMA only overrides the core while it is still asking
  assign dma_force = starve & dma_req;
`else
  assign dma_force = 1'b0;
`endif

  // Grants are combinational; suppressed entirely while reset is held
  assign core_gnt = ~rst & core_req & ~dma_force;
  assign dma_gnt  = ~rst & dma_req & (~core_req | dma_force);
  assign any_gnt  = core_gnt | dma_gnt;

  assign sel_wrb = core_gnt ? core_wrb : dma_wrb;
  assign sel_add = core_gnt ? core_add : dma_add;
  assign sel_wdt = core_gnt ? core_wdt : dma_wdt;

  // Address phase passes straight through on a grant, otherwise the last values hold
  assign arb_dm_cslt = any_gnt;
  assign arb_dm_wrb  = any_gnt ? sel_wrb : wrb_q;
  assign arb_dm_add  = any_gnt ? sel_add : add_q;
  assign arb_dm_wdt  = wdt_q;

  // Record owner of this cycle's access and whether it was a read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= L_NONE;
      last_rd <= 1'b0;
    end else begin
      last    <= core_gnt ? L_CORE : (dma_gnt ? L_DMA : L_NONE);
      last_rd <= any_gnt & ~sel_wrb;
    end
  end

  // Owner tag for the read-return cycle comes from LAST
  assign tag = !last_rd       ? TAG_NONE :
               (last == L_CORE) ? TAG_CORE :
               (last == L_DMA)  ? TAG_DMA  : TAG_NONE;

  // Hold address-phase values and capture write data for the following data phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrb_q <= 1'b0;
      add_q <= '0;
      wdt_q <= '0;
    end else if (any_gnt) begin
      wrb_q <= sel_wrb;
      add_q <= sel_add;
      if (sel_wrb) begin
        wdt_q <= sel_wdt;
      end
    end
  end

  // Route returned DM data to the tagged owner; the other side keeps its last value
  assign core_rvld = tag[1];
  assign dma_rvld  = tag[0];
  assign core_rdt  = tag[1] ? dm_arb_dt : core_rdt_q;
  assign dma_rdt   = tag[0] ? dm_arb_dt : dma_rdt_q;

  // Remember the last data each owner received
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdt_q <= '0;
      dma_rdt_q  <= '0;
    end else begin
      if (tag[1]) core_rdt_q <= dm_arb_dt;
      if (tag[0]) dma_rdt_q  <= dm_arb_dt;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed cases then random traffic against a queue scoreboard.
// Latency: expects grant in the request cycle, wdt/rdt one cycle later.
// Backpressure: the port model holds each request until granted, or withdraws it at random.
module tb_dm_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_wrb, dma_req, dma_wrb;
  logic [AW-1:0] core_add, dma_add;
  logic [DW-1:0] core_wdt, dma_wdt;
  logic          core_gnt, core_rvld, dma_gnt, dma_rvld;
  logic [DW-1:0] core_rdt, dma_rdt;
  logic          arb_dm_cslt, arb_dm_wrb;
  logic [AW-1:0] arb_dm_add;
  logic [DW-1:0] arb_dm_wdt, dm_arb_dt;

  dm_arbiter #(.DMA_SIZE(AW), .DMD_SIZE(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_wrb(core_wrb), .core_add(core_add), .core_wdt(core_wdt),
    .core_gnt(core_gnt), .core_rvld(core_rvld), .core_rdt(core_rdt),
    .dma_req(dma_req), .dma_wrb(dma_wrb), .dma_add(dma_add), .dma_wdt(dma_wdt),
    .dma_gnt(dma_gnt), .dma_rvld(dma_rvld), .dma_rdt(dma_rdt),
    .arb_dm_cslt(arb_dm_cslt), .arb_dm_wrb(arb_dm_wrb), .arb_dm_add(arb_dm_add),
    .arb_dm_wdt(arb_dm_wdt), .dm_arb_dt(dm_arb_dt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic wrb; logic [AW-1:0] add; logic core; } addr_e;
  typedef struct { int cyc; logic [DW-1:0] dat; } dat_e;

  addr_e addr_q[$];
  dat_e  wdt_q[$];
  dat_e  crd_q[$];
  dat_e  drd_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Expected held values, maintained by the scoreboard side
  logic          hold_wrb;
  logic [AW-1:0] hold_add;
  logic [DW-1:0] hold_wdt, hold_crdt, hold_drdt;

  // Port model: one outstanding transaction per port
  logic          c_pend, c_wrb, d_pend, d_wrb;
  logic [AW-1:0] c_add, d_add;
  logic [DW-1:0] c_wdt, d_wdt;
  logic          have_rd;
  logic [DW-1:0] rd_val;
  int            starve;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic missing(input string name, input int due);
    n_chk++;
    n_fail++;
    $display("FAIL %s: expected event due in cycle %0d never seen (now cycle %0d)", name, due, cyc);
  endtask

  // Scoreboard monitor: samples on the falling edge, pops whenever the DUT presents an event
  always @(negedge clk) begin : monitor
    addr_e a;
    dat_e  d;
    if (!rst) begin
      while (addr_q.size() > 0 && addr_q[0].cyc < cyc) begin a = addr_q.pop_front(); missing("grant", a.cyc); end
      if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
        a = addr_q.pop_front();
        check("cslt", {31'd0, arb_dm_cslt}, 32'd1);
        check("core_gnt", {31'd0, core_gnt}, {31'd0, a.core});
        check("dma_gnt", {31'd0, dma_gnt}, {31'd0, ~a.core});
        check("dm_wrb", {31'd0, arb_dm_wrb}, {31'd0, a.wrb});
        check("dm_add", {15'd0, arb_dm_add}, {15'd0, a.add});
        hold_wrb = a.wrb;
        hold_add = a.add;
      end else begin
        check("idle_cslt", {31'd0, arb_dm_cslt}, 32'd0);
        check("idle_gnt", {30'd0, core_gnt, dma_gnt}, 32'd0);
        check("hold_wrb", {31'd0, arb_dm_wrb}, {31'd0, hold_wrb});
        check("hold_add", {15'd0, arb_dm_add}, {15'd0, hold_add});
      end

      while (wdt_q.size() > 0 && wdt_q[0].cyc < cyc) begin d = wdt_q.pop_front(); missing("wdt", d.cyc); end
      if (wdt_q.size() > 0 && wdt_q[0].cyc == cyc) begin
        d = wdt_q.pop_front();
        hold_wdt = d.dat;
      end
      check("dm_wdt", {16'd0, arb_dm_wdt}, {16'd0, hold_wdt});

      while (crd_q.size() > 0 && crd_q[0].cyc < cyc) begin d = crd_q.pop_front(); missing("core_rd", d.cyc); end
      if (crd_q.size() > 0 && crd_q[0].cyc == cyc) begin
        d = crd_q.pop_front();
        check("core_rvld", {31'd0, core_rvld}, 32'd1);
        hold_crdt = d.dat;
      end else begin
        check("core_rvld_idle", {31'd0, core_rvld}, 32'd0);
      end
      check("core_rdt", {16'd0, core_rdt}, {16'd0, hold_crdt});

      while (drd_q.size() > 0 && drd_q[0].cyc < cyc) begin d = drd_q.pop_front(); missing("dma_rd", d.cyc); end
      if (drd_q.size() > 0 && drd_q[0].cyc == cyc) begin
        d = drd_q.pop_front();
        check("dma_rvld", {31'd0, dma_rvld}, 32'd1);
        hold_drdt = d.dat;
      end else begin
        check("dma_rvld_idle", {31'd0, dma_rvld}, 32'd0);
      end
      check("dma_rdt", {16'd0, dma_rdt}, {16'd0, hold_drdt});
    end
  end

  task automatic flush();
    addr_q.delete(); wdt_q.delete(); crd_q.delete(); drd_q.delete();
    hold_wrb = 1'b0; hold_add = '0; hold_wdt = '0; hold_crdt = '0; hold_drdt = '0;
    c_pend = 1'b0; d_pend = 1'b0; have_rd = 1'b0; starve = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_core_gnt"}, {31'd0, core_gnt}, 32'd0);
    check({tag, "_dma_gnt"}, {31'd0, dma_gnt}, 32'd0);
    check({tag, "_cslt"}, {31'd0, arb_dm_cslt}, 32'd0);
    check({tag, "_wrb"}, {31'd0, arb_dm_wrb}, 32'd0);
    check({tag, "_add"}, {15'd0, arb_dm_add}, 32'd0);
    check({tag, "_wdt"}, {16'd0, arb_dm_wdt}, 32'd0);
    check({tag, "_rvld"}, {30'd0, core_rvld, dma_rvld}, 32'd0);
    check({tag, "_core_rdt"}, {16'd0, core_rdt}, 32'd0);
    check({tag, "_dma_rdt"}, {16'd0, dma_rdt}, 32'd0);
  endtask

  // Drive one cycle, decide the winner from the priority rules, queue what must follow
  task automatic cycle_drive();
    logic force_dma, win_c, win_d;
    dm_arb_dt = have_rd ? rd_val : DW'($urandom);
    have_rd   = 1'b0;
    core_req = c_pend; core_wrb = c_wrb; core_add = c_add; core_wdt = c_wdt;
    dma_req  = d_pend; dma_wrb  = d_wrb; dma_add  = d_add; dma_wdt  = d_wdt;
`ifdef DM_ARB_AGING_EN
    force_dma = d_pend && (starve >= LIM);
`else
    force_dma = 1'b0;
`endif
    win_c = c_pend && !force_dma;
    win_d = d_pend && !win_c;
    if (win_c || win_d) begin
      addr_q.push_back('{cyc, win_c ? c_wrb : d_wrb, win_c ? c_add : d_add, win_c});
      if (win_c ? c_wrb : d_wrb) begin
        wdt_q.push_back('{cyc + 1, win_c ? c_wdt : d_wdt});
      end else begin
        rd_val  = DW'($urandom);
        have_rd = 1'b1;
        if (win_c) crd_q.push_back('{cyc + 1, rd_val});
        else       drd_q.push_back('{cyc + 1, rd_val});
      end
    end
`ifdef DM_ARB_AGING_EN
    if (win_d) starve = 0;
    else if (d_pend) starve = (starve + 1 > LIM) ? LIM : starve + 1;
`endif
    if (win_c) c_pend = 1'b0;
    if (win_d) d_pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic wrb, input logic [AW-1:0] add, input logic [DW-1:0] wdt);
    c_pend = 1'b1; c_wrb = wrb; c_add = add; c_wdt = wdt;
  endtask

  task automatic set_dma(input logic wrb, input logic [AW-1:0] add, input logic [DW-1:0] wdt);
    d_pend = 1'b1; d_wrb = wrb; d_add = add; d_wdt = wdt;
  endtask

  // Random request generation; a pending request is occasionally withdrawn before grant
  task automatic gen_reqs();
    if (!c_pend) begin
      if ($urandom_range(0, 3) < 2) set_core(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
    end else if ($urandom_range(0, 15) == 0) c_pend = 1'b0;
    if (!d_pend) begin
      if ($urandom_range(0, 3) < 2) set_dma(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
    end else if ($urandom_range(0, 15) == 0) d_pend = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush();
    c_wrb = 0; c_add = '0; c_wdt = '0; d_wrb = 0; d_add = '0; d_wdt = '0; rd_val = '0;
    core_req = 1'b1; core_wrb = 1'b0; core_add = 17'h0000A; core_wdt = '0;
    dma_req  = 1'b1; dma_wrb  = 1'b0; dma_add  = 17'h00001; dma_wdt  = '0;
    dm_arb_dt = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;

    // Core read of 0x0000A in the first cycle after reset
    set_core(1'b0, 17'h0000A, '0);
    cycle_drive();
    // Core write 0xFFEE to 0x0000F, then idle so the data must hold
    set_core(1'b1, 17'h0000F, 16'hFFEE);
    cycle_drive();
    repeat (3) cycle_drive();
    // Simultaneous requests: core first, DMA on the next free cycle
    set_core(1'b0, 17'h00002, '0);
    set_dma(1'b0, 17'h00004, '0);
    cycle_drive();
    cycle_drive();
    // Write then read of 0x00003 from the other port, back to back
    set_core(1'b1, 17'h00003, 16'hA5C3);
    set_dma(1'b0, 17'h00003, '0);
    cycle_drive();
    cycle_drive();
    cycle_drive();
    // Continuous core pressure against a waiting DMA
    set_dma(1'b1, 17'h00007, 16'h0BEE);
    for (int i = 0; i < 7; i++) begin
      set_core(1'b0, AW'(i), '0);
      cycle_drive();
    end
    repeat (2) cycle_drive();

    // Reset asserted while a core read is returning data
    set_core(1'b0, 17'h00005, '0);
    cycle_drive();
    dm_arb_dt = rd_val;
    core_req = 1'b1; dma_req = 1'b1;
    #1;
    rst = 1'b1;
    flush();
    #1;
    reset_checks("midread");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle_drive();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      gen_reqs();
      cycle_drive();
    end
    c_pend = 1'b0; d_pend = 1'b0;
    repeat (4) cycle_drive();

    check("addr_q_drained", addr_q.size(), 32'd0);
    check("rd_q_drained", crd_q.size() + drd_q.size() + wdt_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DMA_SIZE, default 17: DM address width.
REQ-002 Parameter DMD_SIZE, default 16: DM data width.
REQ-003 Parameter STARVE_LIMIT, default 4: DMA wait cycles before forced grant; range 1..15.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 core_req  in  1  core (DAG) access request, held until granted.
REQ-007 core_wrb  in  1  core: 1 = write, 0 = read.
REQ-008 core_add  in  DMA_SIZE  core DM address.
REQ-009 core_wdt  in  DMD_SIZE  core write data, valid with core_req.
REQ-010 core_gnt  out  1  core request accepted this cycle.
REQ-011 core_rvld  out  1  core read data valid.
REQ-012 core_rdt  out  DMD_SIZE  core read data.
REQ-013 dma_req, dma_wrb, dma_add, dma_wdt, dma_gnt, dma_rvld, dma_rdt: same directions, widths and meanings as REQ-006..012, for the DMA/loader port.
REQ-014 arb_dm_cslt  out  1  DM chip select toward memory.
REQ-015 arb_dm_wrb  out  1  DM write strobe toward memory.
REQ-016 arb_dm_add  out  DMA_SIZE  DM address toward memory.
REQ-017 arb_dm_wdt  out  DMD_SIZE  DM write data, presented one cycle after the address phase.
REQ-018 dm_arb_dt  in  DMD_SIZE  registered DM read data from memory.

Function
REQ-019 The arbiter grants at most one requester per cycle; gnt is combinational from req and registered state.
REQ-020 Default priority is core over DMA.
REQ-021 In a grant cycle, arb_dm_cslt=1 and arb_dm_wrb/arb_dm_add follow the granted requester; with no grant, arb_dm_cslt=0, and arb_dm_wrb and arb_dm_add hold their previous values.
REQ-022 On a granted write, the arbiter registers the write data and drives it on arb_dm_wdt in the next cycle; arb_dm_wdt holds that value until the next write grant.
REQ-023 On a granted read, the arbiter registers a 2-bit owner tag {core, dma} and returns dm_arb_dt in the next cycle on that owner's rdt, with that owner's rvld=1 for exactly one cycle.
REQ-024 The non-owner's rvld=0 and its rdt holds its last value.
REQ-025 Back-to-back grants are legal every cycle, including write-then-read to the same address; the write-data phase overlaps the next address phase.
REQ-026 FSM state LAST in {L_NONE, L_CORE, L_DMA} records the previous cycle's owner; it drives the tag and arb_dm_wdt sourcing.
REQ-027 A request deasserted before grant is dropped without side effect.

Reset
REQ-028 On rst=1 (asynchronous): LAST=L_NONE, owner tag cleared, starve counter=0, arb_dm_cslt=0, arb_dm_wrb=0, arb_dm_add=0, arb_dm_wdt=0, core_rvld=0, dma_rvld=0, core_rdt=0, dma_rdt=0.
REQ-029 While rst=1, core_gnt=0 and dma_gnt=0.
REQ-030 A read granted in the cycle rst asserts returns no rvld.
REQ-031 The first grant is possible in the first cycle after rst deasserts.

Configuration
REQ-032 Macro DM_ARB_AGING_EN: when defined, a 4-bit starve counter increments each cycle dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT, and clears on dma grant.
REQ-033 With DM_ARB_AGING_EN defined and the counter at STARVE_LIMIT, DMA wins the next arbitration over core.
REQ-034 Without DM_ARB_AGING_EN, priority is strictly core-first, no counter exists, and DMA may starve indefinitely.

Structure
REQ-035 Shared package dm_arb_pkg holds the LAST state enum and owner-tag encodings.
REQ-036 One sub-module, dm_arb_starve_ctr, holds the aging counter and is instantiated only under DM_ARB_AGING_EN.

Verification
REQ-037 Core read of addr 0x0000A alone -> core_gnt=1, cslt=1, add=0x0000A in cycle N; core_rvld=1, core_rdt=dm_arb_dt in N+1.
REQ-038 Core write 0xFFEE to 0x0000F -> wrb=1 and add=0x0000F in N; arb_dm_wdt=0xFFEE in N+1 and held afterwards.
REQ-039 Core and DMA both request in one cycle -> core_gnt=1, dma_gnt=0; DMA granted in the first cycle core_req=0.
REQ-040 With DM_ARB_AGING_EN, STARVE_LIMIT=4, and core and DMA requesting continuously -> dma_gnt=1 in the 5th cycle, then the counter is 0.
REQ-041 Write to 0x00003 then a read of 0x00003 from the other port in consecutive cycles -> two grants, wdt phase overlaps the read address phase, only the reader's rvld pulses.
REQ-042 rst asserted mid-read -> all outputs at reset values asynchronously; no rvld after deassertion.
